// File: rtl/execute_multicycle_sequencer.sv
// Issue/stall/writeback sequencer for multi-cycle execute units.
// Runs one operation at a time. Handles kill on clear, result hold across stall_in, and an optional watchdog.
module execute_multicycle_sequencer #(
    parameter int XLEN      = 32,
    parameter int NUM_UNITS = 4,
    parameter int UW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    parameter int TIMEOUT   = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [UW-1:0]             issue_unit,
    input  logic [4:0]                issue_waddr,
    input  logic                      clear,
    input  logic                      stall_in,
    output logic [NUM_UNITS-1:0]      unit_enable,
    output logic [NUM_UNITS-1:0]      unit_kill,
    input  logic [NUM_UNITS-1:0]      unit_ready,
    input  logic [NUM_UNITS*XLEN-1:0] unit_result,
    output logic                      stall,
    output logic                      wren,
    output logic [4:0]                waddr,
    output logic [XLEN-1:0]           wdata,
    output logic                      busy,
    output logic                      err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [UW-1:0]     idx_q, idx_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   buf_q, buf_d;

    logic                 sel_ready;
    logic [XLEN-1:0]      sel_result;
    logic [NUM_UNITS-1:0] idx_mask;
    logic                 issue_ok;
    logic                 timeout_hit;

    // Only the unit that owns the current operation is observed.
    always_comb begin
        sel_ready  = 1'b0;
        sel_result = '0;
        idx_mask   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (idx_q == UW'(i)) begin
                sel_ready   = unit_ready[i];
                sel_result  = unit_result[i*XLEN +: XLEN];
                idx_mask[i] = 1'b1;
            end
        end
    end

    assign issue_ok    = int'(issue_unit) < NUM_UNITS;
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        waddr_d     = waddr_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        unit_enable = '0;
        unit_kill   = '0;
        stall       = 1'b0;
        wren        = 1'b0;
        waddr       = '0;
        wdata       = '0;
        err         = 1'b0;
        busy        = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (issue_valid && !clear && !stall_in) begin
                    if (issue_ok) begin
                        for (int i = 0; i < NUM_UNITS; i++) begin
                            unit_enable[i] = (issue_unit == UW'(i));
                        end
                        stall   = 1'b1;
                        idx_d   = issue_unit;
                        waddr_d = issue_waddr;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (clear) begin
                    unit_kill = idx_mask;
                    state_d   = S_IDLE;
                end else if (sel_ready) begin
                    if (!stall_in) begin
                        if (|waddr_q) begin
                            wren  = 1'b1;
                            waddr = waddr_q;
                            wdata = sel_result;
                        end
                        state_d = S_IDLE;
                    end else begin
                        buf_d   = sel_result;
                        state_d = S_HOLD;
                    end
                end else if (timeout_hit) begin
                    err       = 1'b1;
                    unit_kill = idx_mask;
                    state_d   = S_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                // stall_in already holds the stage; this block adds no stall here.
                if (clear) begin
                    state_d = S_IDLE;
                end else if (!stall_in) begin
                    if (|waddr_q) begin
                        wren  = 1'b1;
                        waddr = waddr_q;
                        wdata = buf_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            waddr_q <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_execute_multicycle_sequencer.sv
// Directed bench for execute_multicycle_sequencer (4 units, 3-bit index, TIMEOUT=8).
module tb_execute_multicycle_sequencer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         issue_valid = 1'b0;
    logic [2:0]   issue_unit = '0;
    logic [4:0]   issue_waddr = '0;
    logic         clear = 1'b0;
    logic         stall_in = 1'b0;
    logic [3:0]   unit_enable;
    logic [3:0]   unit_kill;
    logic [3:0]   unit_ready = '0;
    logic [127:0] unit_result = '0;
    logic         stall;
    logic         wren;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         busy;
    logic         err;

    int checks = 0;
    int failures = 0;

    execute_multicycle_sequencer #(
        .XLEN(32), .NUM_UNITS(4), .UW(3), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_waddr(issue_waddr),
        .clear(clear), .stall_in(stall_in),
        .unit_enable(unit_enable), .unit_kill(unit_kill),
        .unit_ready(unit_ready), .unit_result(unit_result),
        .stall(stall), .wren(wren), .waddr(waddr), .wdata(wdata),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    // Observed bundle: {enable, kill, stall, wren, waddr, wdata, busy, err}
    logic [48:0] obs;
    assign obs = {unit_enable, unit_kill, stall, wren, waddr, wdata, busy, err};

    function automatic logic [48:0] ev(input logic [3:0] en, input logic [3:0] kl,
                                       input logic st, input logic wr, input logic [4:0] wa,
                                       input logic [31:0] wd, input logic bz, input logic er);
        return {en, kl, st, wr, wa, wd, bz, er};
    endfunction

    task automatic nc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_unit = '0; issue_waddr = '0;
        clear = 1'b0; stall_in = 1'b0; unit_ready = '0; unit_result = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        nc(); nc(); #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs, ev(0,0,0,0,0,0,0,0)); end
        reset = 1'b0;
        nc(); #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL reset_released got=%h exp=%h", obs, ev(0,0,0,0,0,0,0,0)); end
    endtask

    task automatic test_mul(input logic [4:0] wa, input string nm);
        logic [48:0] e;
        nc(); issue_valid = 1'b1; issue_unit = 3'd1; issue_waddr = wa; #1;
        e = ev(4'b0010,0,1,0,0,0,0,0);
        checks++; if (obs !== e) begin failures++; $display("FAIL %s_c0 got=%h exp=%h", nm, obs, e); end
        for (int c = 1; c <= 2; c++) begin
            nc(); issue_valid = 1'b0; #1;
            e = ev(0,0,1,0,0,0,1,0);
            checks++; if (obs !== e) begin failures++; $display("FAIL %s_c%0d got=%h exp=%h", nm, c, obs, e); end
        end
        nc(); unit_ready = 4'b0010; unit_result[32 +: 32] = 32'hDEADBEEF; #1;
        e = (wa != 0) ? ev(0,0,0,1,wa,32'hDEADBEEF,1,0) : ev(0,0,0,0,0,0,1,0);
        checks++; if (obs !== e) begin failures++; $display("FAIL %s_wb got=%h exp=%h", nm, obs, e); end
        nc(); idle_inputs(); #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL %s_idle got=%h exp=0", nm, obs); end
    endtask

    task automatic test_hold();
        logic [48:0] e;
        nc(); issue_valid = 1'b1; issue_unit = 3'd2; issue_waddr = 5'd7; #1;
        checks++; if (obs !== ev(4'b0100,0,1,0,0,0,0,0)) begin failures++; $display("FAIL hold_accept got=%h", obs); end
        nc(); issue_valid = 1'b0; #1;
        nc(); unit_ready = 4'b0100; unit_result[64 +: 32] = 32'h12345678; stall_in = 1'b1; #1;
        e = ev(0,0,0,0,0,0,1,0);
        checks++; if (obs !== e) begin failures++; $display("FAIL hold_capture got=%h exp=%h", obs, e); end
        nc(); unit_ready = '0; unit_result[64 +: 32] = 32'hBAD0BAD0; #1;
        checks++; if (obs !== e) begin failures++; $display("FAIL hold_wait got=%h exp=%h", obs, e); end
        nc(); stall_in = 1'b0; #1;
        e = ev(0,0,0,1,5'd7,32'h12345678,1,0);
        checks++; if (obs !== e) begin failures++; $display("FAIL hold_release got=%h exp=%h", obs, e); end
        nc(); idle_inputs(); #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL hold_idle got=%h exp=0", obs); end
    endtask

    task automatic test_clear();
        logic [48:0] e;
        nc(); issue_valid = 1'b1; issue_unit = 3'd3; issue_waddr = 5'd9; #1;
        checks++; if (obs !== ev(4'b1000,0,1,0,0,0,0,0)) begin failures++; $display("FAIL clr_accept got=%h", obs); end
        nc(); issue_valid = 1'b0; #1;
        nc(); clear = 1'b1; unit_ready = 4'b1000; unit_result[96 +: 32] = 32'h0BADF00D; #1;
        e = ev(0,4'b1000,0,0,0,0,1,0);
        checks++; if (obs !== e) begin failures++; $display("FAIL clr_kill got=%h exp=%h", obs, e); end
        nc(); clear = 1'b0; #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL clr_late_ready got=%h exp=0", obs); end
        // Clear in IDLE blocks the accept.
        nc(); idle_inputs(); issue_valid = 1'b1; issue_unit = 3'd1; issue_waddr = 5'd3; clear = 1'b1; #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL clr_idle got=%h exp=0", obs); end
        nc(); idle_inputs(); #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL clr_idle_next got=%h exp=0", obs); end
    endtask

    task automatic test_timeout();
        logic [48:0] e;
        nc(); issue_valid = 1'b1; issue_unit = 3'd1; issue_waddr = 5'd4; #1;
        checks++; if (obs !== ev(4'b0010,0,1,0,0,0,0,0)) begin failures++; $display("FAIL to_accept got=%h", obs); end
        for (int c = 1; c <= 7; c++) begin
            nc(); issue_valid = 1'b0; #1;
            e = ev(0,0,1,0,0,0,1,0);
            checks++; if (obs !== e) begin failures++; $display("FAIL to_wait_c%0d got=%h exp=%h", c, obs, e); end
        end
        nc(); #1;
        e = ev(0,4'b0010,0,0,0,0,1,1);
        checks++; if (obs !== e) begin failures++; $display("FAIL to_fire got=%h exp=%h", obs, e); end
        nc(); #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL to_idle got=%h exp=0", obs); end
    endtask

    task automatic test_invalid();
        nc(); issue_valid = 1'b1; issue_unit = 3'd5; issue_waddr = 5'd6; #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,1)) begin failures++; $display("FAIL inv_err got=%h exp=%h", obs, ev(0,0,0,0,0,0,0,1)); end
        nc(); idle_inputs(); #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL inv_idle got=%h exp=0", obs); end
    endtask

    task automatic test_back_to_back();
        logic [48:0] e;
        nc(); issue_valid = 1'b1; issue_unit = 3'd0; issue_waddr = 5'd10; #1;
        checks++; if (obs !== ev(4'b0001,0,1,0,0,0,0,0)) begin failures++; $display("FAIL b2b_a_accept got=%h", obs); end
        nc(); unit_ready = 4'b1000; unit_result[96 +: 32] = 32'hFFFF0003; #1;
        e = ev(0,0,1,0,0,0,1,0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_spurious got=%h exp=%h", obs, e); end
        nc(); unit_ready = 4'b0001; unit_result[0 +: 32] = 32'hAAAA0001; #1;
        e = ev(0,0,0,1,5'd10,32'hAAAA0001,1,0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_a_write got=%h exp=%h", obs, e); end
        nc(); unit_ready = '0; issue_unit = 3'd2; issue_waddr = 5'd11; #1;
        checks++; if (obs !== ev(4'b0100,0,1,0,0,0,0,0)) begin failures++; $display("FAIL b2b_b_accept got=%h", obs); end
        nc(); issue_valid = 1'b0; unit_ready = 4'b0100; unit_result[64 +: 32] = 32'hBBBB0002; #1;
        e = ev(0,0,0,1,5'd11,32'hBBBB0002,1,0);
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_b_write got=%h exp=%h", obs, e); end
        nc(); idle_inputs(); #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL b2b_idle got=%h exp=0", obs); end
    endtask

    task automatic test_reset_mid();
        nc(); issue_valid = 1'b1; issue_unit = 3'd2; issue_waddr = 5'd12; #1;
        nc(); issue_valid = 1'b0; #1;
        checks++; if (obs !== ev(0,0,1,0,0,0,1,0)) begin failures++; $display("FAIL rmid_wait got=%h", obs); end
        nc(); reset = 1'b1; #1;
        nc(); #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL rmid_reset got=%h exp=0", obs); end
        nc(); reset = 1'b0; unit_ready = 4'b0100; unit_result[64 +: 32] = 32'hCCCC0004; #1;
        checks++; if (obs !== ev(0,0,0,0,0,0,0,0)) begin failures++; $display("FAIL rmid_late_ready got=%h exp=0", obs); end
        nc(); idle_inputs(); #1;
    endtask

    initial begin
        test_reset();
        test_mul(5'd5, "mul");
        test_mul(5'd0, "mul_r0");
        test_hold();
        test_clear();
        test_timeout();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_time_limit reached got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
